// File: rtl/jump_resolve_ctrl_if.sv
// Handshake and data bundle between the issue stage, jump FU, redirect logic and writeback.
// The slave modport is the controller side, and the master modport is its environment.
interface jump_resolve_ctrl_if;
  logic        issue_valid;
  logic        issue_ready;
  logic        issue_is_branch;
  logic [4:0]  issue_rd;
  logic        fu_en;
  logic        fu_finish;
  logic        fu_cmp_res;
  logic [31:0] fu_pc_jump;
  logic [31:0] fu_pc_wb;
  logic        kill;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        misalign;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  issue_valid, issue_is_branch, issue_rd,
    input  fu_finish, fu_cmp_res, fu_pc_jump, fu_pc_wb,
    input  kill, wb_ready,
    output issue_ready, fu_en, redirect_valid, redirect_pc, flush, misalign,
    output wb_valid, wb_rd, wb_data, busy, timeout_err
  );

  modport master (
    output issue_valid, issue_is_branch, issue_rd,
    output fu_finish, fu_cmp_res, fu_pc_jump, fu_pc_wb,
    output kill, wb_ready,
    input  issue_ready, fu_en, redirect_valid, redirect_pc, flush, misalign,
    input  wb_valid, wb_rd, wb_data, busy, timeout_err
  );
endinterface

// File: rtl/jump_resolve_ctrl.sv
// Jump/branch resolve sequencer: accept, one-cycle fu_en, redirect 2 cycles after accept+1, wb from accept+4.
// One jump in flight; issue_ready only in IDLE, and the writeback holds until wb_ready.
module jump_resolve_ctrl #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst_n,
  jump_resolve_ctrl_if.slave jif
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] RESOLVE = 3'd3;
  localparam logic [2:0] WB      = 3'd4;

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          err_q, err_d;
  logic          is_branch_q, is_branch_d;
  logic [4:0]    rd_q, rd_d;
  logic          cmp_q, cmp_d;
  logic [31:0]   pc_jump_q, pc_jump_d;
  logic [31:0]   pc_wb_q, pc_wb_d;
  logic          taken;
  logic          redir;

  assign cnt_inc = (cnt_q == TMAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    is_branch_d = is_branch_q;
    rd_d        = rd_q;
    cmp_d       = cmp_q;
    pc_jump_d   = pc_jump_q;
    pc_wb_d     = pc_wb_q;
    case (state_q)
      IDLE: begin
        if (jif.issue_valid) begin
          state_d     = START;
          is_branch_d = jif.issue_is_branch;
          rd_d        = jif.issue_rd;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = jif.kill ? IDLE : WAIT;
      end
      WAIT: begin
        // kill beats a simultaneous finish, so nothing is captured in that case
        if (jif.kill) begin
          state_d = IDLE;
        end else if (jif.fu_finish) begin
          state_d   = RESOLVE;
          cmp_d     = jif.fu_cmp_res;
          pc_jump_d = jif.fu_pc_jump;
          pc_wb_d   = jif.fu_pc_wb;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMAX) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      RESOLVE: begin
        if (jif.kill) begin
          state_d = IDLE;
        end else if (!is_branch_q && (rd_q != 5'd0)) begin
          state_d = WB;
        end else begin
          state_d = IDLE;
        end
      end
      WB: begin
        if (jif.wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      is_branch_q <= 1'b0;
      rd_q        <= 5'd0;
      cmp_q       <= 1'b0;
      pc_jump_q   <= 32'd0;
      pc_wb_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      is_branch_q <= is_branch_d;
      rd_q        <= rd_d;
      cmp_q       <= cmp_d;
      pc_jump_q   <= pc_jump_d;
      pc_wb_q     <= pc_wb_d;
    end
  end

  assign taken = ~is_branch_q | cmp_q;
  assign redir = (state_q == RESOLVE) & taken & ~jif.kill;

  // ready is gated by rst_n so it stays low while reset is held
  assign jif.issue_ready    = (state_q == IDLE) & rst_n;
  assign jif.fu_en          = (state_q == START) & ~jif.kill;
  assign jif.redirect_valid = redir;
  assign jif.flush          = redir;
  assign jif.redirect_pc    = redir ? {pc_jump_q[31:1], 1'b0} : 32'd0;
  assign jif.misalign       = redir & pc_jump_q[1];
  assign jif.wb_valid       = (state_q == WB);
  assign jif.wb_rd          = (state_q == WB) ? rd_q : 5'd0;
  assign jif.wb_data        = (state_q == WB) ? pc_wb_q : 32'd0;
  assign jif.busy           = (state_q != IDLE);
  assign jif.timeout_err    = err_q;

endmodule

// File: tb/tb_jump_resolve_ctrl.sv
// Self-checking bench for jump_resolve_ctrl: directed cases plus randomized jumps checked
// against a per-transaction expectation derived from the taken/writeback rules.
module tb_jump_resolve_ctrl;
    localparam int TIMEOUT = 8;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    logic err_exp;

    jump_resolve_ctrl_if j();

    jump_resolve_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .jif   (j)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        j.issue_valid     = 1'b0;
        j.issue_is_branch = 1'b0;
        j.issue_rd        = 5'd0;
        j.fu_finish       = 1'b0;
        j.fu_cmp_res      = 1'b0;
        j.fu_pc_jump      = 32'd0;
        j.fu_pc_wb        = 32'd0;
        j.kill            = 1'b0;
        j.wb_ready        = 1'b0;
    endtask

    task automatic chk_all_zero();
        chk("rst_issue_ready", j.issue_ready, 1'b0);
        chk("rst_fu_en", j.fu_en, 1'b0);
        chk("rst_redirect_valid", j.redirect_valid, 1'b0);
        chk("rst_redirect_pc", j.redirect_pc, 32'd0);
        chk("rst_flush", j.flush, 1'b0);
        chk("rst_misalign", j.misalign, 1'b0);
        chk("rst_wb_valid", j.wb_valid, 1'b0);
        chk("rst_wb_rd", j.wb_rd, 5'd0);
        chk("rst_wb_data", j.wb_data, 32'd0);
        chk("rst_busy", j.busy, 1'b0);
        chk("rst_timeout_err", j.timeout_err, 1'b0);
    endtask

    // fin_dly: WAIT cycles before finish (>= TIMEOUT means never);
    // kill_at: -1 none, 1 START, 2 with finish in WAIT, 3 RESOLVE.
    task automatic run_txn(input logic br, input logic [4:0] rd, input logic cmp,
                           input logic [31:0] pcj, input logic [31:0] pcw,
                           input int fin_dly, input int stall, input int kill_at);
        logic        taken, wbx, tmo, k, fin;
        logic [31:0] exp_pc;
        int          nwait;
        taken  = !br || cmp;
        wbx    = !br && (rd != 5'd0);
        tmo    = (fin_dly >= TIMEOUT);
        exp_pc = pcj & 32'hFFFF_FFFE;

        @(negedge clk);
        clear_inputs();
        j.issue_valid = 1'b1; j.issue_is_branch = br; j.issue_rd = rd;
        #1;
        chk("accept_issue_ready", j.issue_ready, 1'b1);
        chk("accept_busy", j.busy, 1'b0);
        chk("accept_timeout_err", j.timeout_err, err_exp);

        @(negedge clk);
        j.issue_valid = 1'($urandom_range(0, 1)); j.issue_is_branch = 1'($urandom_range(0, 1));
        j.issue_rd = 5'($urandom); j.fu_finish = 1'($urandom_range(0, 1));
        j.fu_cmp_res = 1'($urandom_range(0, 1)); j.fu_pc_jump = $urandom; j.fu_pc_wb = $urandom;
        j.kill = (kill_at == 1);
        #1;
        chk("start_fu_en", j.fu_en, (kill_at != 1));
        chk("start_busy", j.busy, 1'b1);
        chk("start_issue_ready", j.issue_ready, 1'b0);
        if (kill_at == 1) begin
            @(negedge clk); clear_inputs(); #1;
            chk("kstart_busy", j.busy, 1'b0);
            chk("kstart_issue_ready", j.issue_ready, 1'b1);
            return;
        end

        nwait = tmo ? TIMEOUT : fin_dly + 1;
        for (int w = 0; w < nwait; w++) begin
            @(negedge clk);
            fin = !tmo && (w == fin_dly);
            j.fu_finish  = fin;
            j.fu_cmp_res = fin ? cmp : 1'($urandom_range(0, 1));
            j.fu_pc_jump = fin ? pcj : $urandom;
            j.fu_pc_wb   = fin ? pcw : $urandom;
            j.kill       = fin && (kill_at == 2);
            j.issue_valid = 1'($urandom_range(0, 1));
            #1;
            chk("wait_fu_en", j.fu_en, 1'b0);
            chk("wait_busy", j.busy, 1'b1);
            chk("wait_redirect", j.redirect_valid, 1'b0);
            chk("wait_wb_valid", j.wb_valid, 1'b0);
        end

        if (tmo) begin
            err_exp = 1'b1;
            @(negedge clk); clear_inputs(); #1;
            chk("tmo_timeout_err", j.timeout_err, 1'b1);
            chk("tmo_issue_ready", j.issue_ready, 1'b1);
            chk("tmo_busy", j.busy, 1'b0);
            chk("tmo_redirect", j.redirect_valid, 1'b0);
            return;
        end
        if (kill_at == 2) begin
            @(negedge clk); clear_inputs(); #1;
            chk("kfin_busy", j.busy, 1'b0);
            chk("kfin_redirect", j.redirect_valid, 1'b0);
            chk("kfin_wb_valid", j.wb_valid, 1'b0);
            return;
        end

        @(negedge clk);
        k = (kill_at == 3);
        j.kill = k; j.fu_finish = 1'($urandom_range(0, 1));
        j.fu_cmp_res = 1'($urandom_range(0, 1)); j.fu_pc_jump = $urandom; j.fu_pc_wb = $urandom;
        #1;
        chk("res_redirect_valid", j.redirect_valid, (taken && !k));
        chk("res_flush", j.flush, (taken && !k));
        chk("res_redirect_pc", j.redirect_pc, ((taken && !k) ? exp_pc : 32'd0));
        chk("res_misalign", j.misalign, (taken && !k && pcj[1]));
        chk("res_wb_valid", j.wb_valid, 1'b0);
        if (k || !wbx) begin
            @(negedge clk); clear_inputs(); #1;
            chk("done_busy", j.busy, 1'b0);
            chk("done_issue_ready", j.issue_ready, 1'b1);
            chk("done_redirect", j.redirect_valid, 1'b0);
            chk("done_wb_valid", j.wb_valid, 1'b0);
            return;
        end

        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            j.kill = 1'($urandom_range(0, 1)); j.wb_ready = (s == stall);
            j.fu_finish = 1'($urandom_range(0, 1)); j.fu_pc_wb = $urandom;
            #1;
            chk("wb_valid", j.wb_valid, 1'b1);
            chk("wb_rd", j.wb_rd, rd);
            chk("wb_data", j.wb_data, pcw);
            chk("wb_redirect", j.redirect_valid, 1'b0);
        end
        @(negedge clk); clear_inputs(); #1;
        chk("wbdone_wb_valid", j.wb_valid, 1'b0);
        chk("wbdone_busy", j.busy, 1'b0);
        chk("wbdone_issue_ready", j.issue_ready, 1'b1);
    endtask

    initial begin
        logic        r_br, r_cmp;
        logic [4:0]  r_rd;
        int          r_fin, r_stall, r_kill, sel;
        vectors = 0; miscompares = 0; err_exp = 1'b0;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        chk_all_zero();
        @(negedge clk); rst_n = 1'b1; #1;
        chk("post_rst_issue_ready", j.issue_ready, 1'b1);

        run_txn(1'b0, 5'd1, 1'b0, 32'h100, 32'h24, 0, 0, -1);
        run_txn(1'b1, 5'd3, 1'b0, 32'h80, 32'h10, 0, 0, -1);
        run_txn(1'b1, 5'd3, 1'b1, 32'h80, 32'h10, 0, 0, -1);
        run_txn(1'b0, 5'd0, 1'b0, 32'h203, 32'h44, 0, 0, -1);
        run_txn(1'b0, 5'd5, 1'b0, 32'h300, 32'h58, 0, 3, -1);
        run_txn(1'b0, 5'd7, 1'b0, 32'h400, 32'h60, 1, 0, 2);
        run_txn(1'b0, 5'd4, 1'b0, 32'h500, 32'h64, 0, 0, 1);
        run_txn(1'b0, 5'd6, 1'b1, 32'h602, 32'h68, 2, 0, 3);
        run_txn(1'b0, 5'd2, 1'b0, 32'h700, 32'h6c, TIMEOUT, 0, -1);

        for (int n = 0; n < 40; n++) begin
            r_br    = 1'($urandom_range(0, 1));
            r_cmp   = 1'($urandom_range(0, 1));
            r_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            r_fin   = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
            r_stall = $urandom_range(0, 3);
            sel     = $urandom_range(0, 9);
            r_kill  = (sel == 0) ? 1 : (sel == 1 && r_fin < TIMEOUT) ? 2 : (sel == 2) ? 3 : -1;
            run_txn(r_br, r_rd, r_cmp, $urandom, $urandom, r_fin, r_stall, r_kill);
        end

        @(negedge clk); clear_inputs();
        j.issue_valid = 1'b1; j.issue_rd = 5'd9;
        @(negedge clk); j.issue_valid = 1'b0;
        @(negedge clk); #1;
        chk("prerst_busy", j.busy, 1'b1);
        rst_n = 1'b0; #1;
        chk_all_zero();
        @(negedge clk); rst_n = 1'b1; err_exp = 1'b0; #1;
        chk("rerst_issue_ready", j.issue_ready, 1'b1);
        chk("rerst_busy", j.busy, 1'b0);
        run_txn(1'b0, 5'd1, 1'b0, 32'h100, 32'h24, 0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
